// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - state encodings, ex_type codes and request helpers for mem_access_unit
package mem_access_unit_pkg;

    localparam logic [2:0] MEM_ST_IDLE = 3'd0;
    localparam logic [2:0] MEM_ST_RD   = 3'd1;
    localparam logic [2:0] MEM_ST_LDR  = 3'd2;
    localparam logic [2:0] MEM_ST_MRG  = 3'd3;
    localparam logic [2:0] MEM_ST_WR   = 3'd4;
    localparam logic [2:0] MEM_ST_ERR  = 3'd5;

    localparam logic [1:0] MEM_EX_WORD = 2'b00;
    localparam logic [1:0] MEM_EX_BYTE = 2'b01;
    localparam logic [1:0] MEM_EX_HALF = 2'b10;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } mem_size_e;

    typedef struct packed {
        logic        we;
        logic [1:0]  ex_type;
        logic        is_unsigned;
        logic [1:0]  lane;
        logic [31:0] wdata;
    } mem_cap_t;

    // The byte bit wins so that ex_type 11 behaves as a byte access.
    function automatic mem_size_e decode_size(input logic [1:0] ex_type);
        if (ex_type[0])
            return SZ_BYTE;
        else if (ex_type[1])
            return SZ_HALF;
        else
            return SZ_WORD;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] ex_type, input logic [1:0] lane);
        case (decode_size(ex_type))
            SZ_HALF: return lane[0];
            SZ_WORD: return |lane;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_merge.sv
// rtl/mem_lane_merge.sv - combinational sub-word store merge and load lane extract/extend
module mem_lane_merge
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]  ex_type,
    input  logic        is_unsigned,
    input  logic [1:0]  lane,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] merged,
    output logic [31:0] loaded
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign sel_byte = rdata[{lane, 3'b000} +: 8];
    assign sel_half = lane[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        merged = rdata;
        loaded = rdata;
        case (decode_size(ex_type))
            SZ_BYTE: begin
                merged[{lane, 3'b000} +: 8] = wdata[7:0];
                loaded = {{24{~is_unsigned & sel_byte[7]}}, sel_byte};
            end
            SZ_HALF: begin
                merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
                loaded = {{16{~is_unsigned & sel_half[15]}}, sel_half};
            end
            default: begin
                merged = wdata;
                loaded = rdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store access stage driving a word-wide synchronous DRAM port
// Optional MEM_MISALIGN_TRAP_EN: misaligned half/word requests complete through ERR with rsp_misalign.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_ex_type,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic [ADDR_W-1:0] dram_addr,
    output logic              dram_we,
    output logic [31:0]       dram_wdata,
    input  logic [31:0]       dram_rdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_misalign
);

    logic [2:0]        state_q, state_d;
    mem_cap_t          cap_q, cap_d;
    logic [ADDR_W-1:0] dram_addr_q, dram_addr_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              accept;
    logic              trap_req;
    logic [31:0]       merged_word;
    logic [31:0]       loaded_word;
    logic              unused_addr_hi;

    assign accept         = req_valid && req_ready;
    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

`ifdef MEM_MISALIGN_TRAP_EN
    logic rsp_misalign_q, rsp_misalign_d;

    assign trap_req       = is_misaligned(req_ex_type, req_addr[1:0]);
    assign rsp_misalign_d = (state_q == MEM_ST_ERR);
    assign rsp_misalign   = rsp_misalign_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rsp_misalign_q <= 1'b0;
        else
            rsp_misalign_q <= rsp_misalign_d;
    end
`else
    assign trap_req     = 1'b0;
    assign rsp_misalign = 1'b0;
`endif

    mem_lane_merge u_lane_merge (
        .ex_type     (cap_q.ex_type),
        .is_unsigned (cap_q.is_unsigned),
        .lane        (cap_q.lane),
        .rdata       (dram_rdata),
        .wdata       (cap_q.wdata),
        .merged      (merged_word),
        .loaded      (loaded_word)
    );

    always_comb begin
        state_d     = state_q;
        cap_d       = cap_q;
        dram_addr_d = dram_addr_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            MEM_ST_IDLE: begin
                if (accept) begin
                    cap_d.we          = req_we;
                    cap_d.ex_type     = req_ex_type;
                    cap_d.is_unsigned = req_unsigned;
                    cap_d.lane        = req_addr[1:0];
                    cap_d.wdata       = req_wdata;
                    if (trap_req) begin
                        state_d = MEM_ST_ERR;
                    end else begin
                        // The word address is latched here so dram_addr holds between accesses.
                        dram_addr_d = req_addr[ADDR_W+1:2];
                        state_d = (req_we && decode_size(req_ex_type) == SZ_WORD) ? MEM_ST_WR
                                                                                  : MEM_ST_RD;
                    end
                end
            end
            MEM_ST_RD:  state_d = cap_q.we ? MEM_ST_MRG : MEM_ST_LDR;
            MEM_ST_LDR: begin
                rsp_rdata_d = loaded_word;
                rsp_valid_d = 1'b1;
                state_d     = MEM_ST_IDLE;
            end
            MEM_ST_MRG, MEM_ST_WR, MEM_ST_ERR: begin
                rsp_valid_d = 1'b1;
                state_d     = MEM_ST_IDLE;
            end
            default:    state_d = MEM_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= MEM_ST_IDLE;
            cap_q       <= '0;
            dram_addr_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            cap_q       <= cap_d;
            dram_addr_q <= dram_addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign req_ready  = (state_q == MEM_ST_IDLE);
    assign dram_we    = (state_q == MEM_ST_MRG) || (state_q == MEM_ST_WR);
    assign dram_wdata = (state_q == MEM_ST_WR) ? cap_q.wdata : merged_word;
    assign dram_addr  = dram_addr_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;

endmodule
